// File: rtl/sr_button_pkg.sv
// Shared types and sizing helpers for the SR-latch button driver.
package sr_button_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    GAP     = 2'd3
  } state_e;

  // Bits needed to hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchroniser, stable-count debouncer and one-cycle press request
// for a single raw pushbutton.
module sr_debounce
  import sr_button_pkg::*;
#(
  parameter int DEB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic req
);

  localparam int              CW       = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          level_q, level_d;
  logic          req_q,   req_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    req_d   = 1'b0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        // Only a press (0 -> 1) is a request; releases are ignored.
        req_d   = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      meta_q  <= btn;
      sync_q  <= meta_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      req_q   <= req_d;
    end
  end

  assign req = req_q;

endmodule

// File: rtl/sr_button_driver.sv
// Turns two bouncing buttons into clean, fixed-width, mutually exclusive S/R
// pulses for a NOR SR latch, with a guaranteed idle gap between pulses.
module sr_button_driver
  import sr_button_pkg::*;
#(
  parameter int DEB_CYCLES   = 1000,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN_S,
  input  logic BTN_R,
  output logic S,
  output logic R,
  output logic BUSY,
  output logic CONFLICT
);

  localparam int            CW         = cnt_width(max_int(PULSE_CYCLES, GAP_CYCLES));
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  logic req_s, req_r;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_s (
    .clk   (CLK),
    .rst_n (RST_N),
    .btn   (BTN_S),
    .req   (req_s)
  );

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
    .clk   (CLK),
    .rst_n (RST_N),
    .btn   (BTN_R),
    .req   (req_r)
  );

  state_e        state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          pend_s_q, pend_s_d;
  logic          pend_r_q, pend_r_d;
  logic          hit_q,    hit_d;
  logic          s_q, r_q, busy_q, conflict_q;
  logic          want_s, want_r;

  assign want_s = req_s | pend_s_q;
  assign want_r = req_r | pend_r_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_s_d = pend_s_q;
    pend_r_d = pend_r_q;
    hit_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Live requests and pending flags are served alike; anything seen
        // here is consumed, including a discarded S+R pair.
        pend_s_d = 1'b0;
        pend_r_d = 1'b0;
        cnt_d    = '0;
        if (want_s && want_r) hit_d   = 1'b1;
        else if (want_s)      state_d = PULSE_S;
        else if (want_r)      state_d = PULSE_R;
      end
      PULSE_S, PULSE_R: begin
        pend_s_d = pend_s_q | req_s;
        pend_r_d = pend_r_q | req_r;
        if (cnt_q == PULSE_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        pend_s_d = pend_s_q | req_s;
        pend_r_d = pend_r_q | req_r;
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are glitch-free flops
  // aligned with the state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_s_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      hit_q      <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_s_q   <= pend_s_d;
      pend_r_q   <= pend_r_d;
      hit_q      <= hit_d;
      s_q        <= (state_d == PULSE_S);
      r_q        <= (state_d == PULSE_R);
      busy_q     <= (state_d != IDLE);
      conflict_q <= hit_q;
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign BUSY     = busy_q;
  assign CONFLICT = conflict_q;

endmodule

// File: tb/tb_sr_button_driver.sv
// Directed bench for sr_button_driver with DEB=8, PULSE=4, GAP=2; edge numbers
// count rising edges after reset release or after the buttons change.
module tb_sr_button_driver;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_s, btn_r;
  logic s, r, busy, conflict;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sr_button_driver #(
    .DEB_CYCLES   (8),
    .PULSE_CYCLES (4),
    .GAP_CYCLES   (2)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .BTN_S    (btn_s),
    .BTN_R    (btn_r),
    .S        (s),
    .R        (r),
    .BUSY     (busy),
    .CONFLICT (conflict)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges with buttons low; the next edge is edge 1.
  task automatic do_reset();
    btn_s = 1'b0;
    btn_r = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_s",        s,        1'b0);
    check("rst_r",        r,        1'b0);
    check("rst_busy",     busy,     1'b0);
    check("rst_conflict", conflict, 1'b0);
    rst_n = 1'b1;
  endtask

  // The latch must never see S and R together.
  always @(negedge clk) check("s_and_r", s & r, 1'b0);

  initial begin
    btn_s = 1'b0;
    btn_r = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Clean press: S after edges 11..14, BUSY after edges 11..16.
    do_reset();
    btn_s = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check($sformatf("clean_s_e%0d", e),    s,        (e >= 11 && e <= 14));
      check($sformatf("clean_r_e%0d", e),    r,        1'b0);
      check($sformatf("clean_busy_e%0d", e), busy,     (e >= 11 && e <= 16));
      check($sformatf("clean_cf_e%0d", e),   conflict, 1'b0);
    end

    // Bounce: BTN_R toggles every 3 cycles for 30 cycles, then stays low.
    do_reset();
    for (int e = 1; e <= 50; e++) begin
      btn_r = (e <= 30) ? (((e - 1) / 3) % 2 == 0) : 1'b0;
      tick();
      check($sformatf("bounce_r_e%0d", e),    r,    1'b0);
      check($sformatf("bounce_busy_e%0d", e), busy, 1'b0);
    end

    // Simultaneous press: dropped, CONFLICT only after edge 12.
    do_reset();
    btn_s = 1'b1;
    btn_r = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check($sformatf("simul_s_e%0d", e),    s,        1'b0);
      check($sformatf("simul_r_e%0d", e),    r,        1'b0);
      check($sformatf("simul_busy_e%0d", e), busy,     1'b0);
      check($sformatf("simul_cf_e%0d", e),   conflict, (e == 12));
    end

    // Pending: R debounced during the S pulse is served after gap + 1 IDLE.
    do_reset();
    btn_s = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      if (e == 3) btn_r = 1'b1;
      tick();
      check($sformatf("pend_s_e%0d", e),    s,        (e >= 11 && e <= 14));
      check($sformatf("pend_r_e%0d", e),    r,        (e >= 18 && e <= 21));
      check($sformatf("pend_busy_e%0d", e), busy,     ((e >= 11 && e <= 16) || (e >= 18 && e <= 23)));
      check($sformatf("pend_cf_e%0d", e),   conflict, 1'b0);
    end

    // Reset two cycles into an S pulse, BTN_S held throughout.
    do_reset();
    btn_s = 1'b1;
    for (int e = 1; e <= 12; e++) tick();
    check("midrst_pre_s", s, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_async_s",    s,    1'b0);
    check("midrst_async_busy", busy, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick();
      check($sformatf("midrst_s_e%0d", e),    s,    (e >= 11 && e <= 14));
      check($sformatf("midrst_r_e%0d", e),    r,    1'b0);
      check($sformatf("midrst_busy_e%0d", e), busy, (e >= 11 && e <= 16));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
